// File: rtl/axis_param_fifo.sv
// Parametrised AXI4-Stream synchronous FIFO with TKEEP/TUSER/TLAST carriage and beat/packet counters.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward; the default build is cut-through.
module axis_param_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [CNT_W-1:0]        data_count,
    output logic [CNT_W-1:0]        pkt_count
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int BEAT_W = DATA_WIDTH + KEEP_W + USER_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [BEAT_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  wr_ptr_nxt;
    logic [CNT_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  pkt_nxt;
    logic [BEAT_W-1:0] s_beat;
    logic [BEAT_W-1:0] head_nxt;
    logic              push;
    logic              pop;
    logic              head_from_input;
    logic              load_head;
    logic              valid_nxt;

    assign s_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    assign push   = s_axis_tvalid && s_axis_tready;
    assign pop    = m_axis_tvalid && m_axis_tready;

    // The output register always mirrors the oldest stored beat, so it is part of the DEPTH entries.
    always_comb begin
        wr_ptr_nxt = push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_nxt = pop  ? rd_ptr + 1'b1 : rd_ptr;
        cnt_nxt    = data_count;
        case ({push, pop})
            2'b10:   cnt_nxt = data_count + 1'b1;
            2'b01:   cnt_nxt = data_count - 1'b1;
            default: cnt_nxt = data_count;
        endcase
        pkt_nxt = pkt_count;
        case ({push && s_axis_tlast, pop && m_axis_tlast})
            2'b10:   pkt_nxt = pkt_count + 1'b1;
            2'b01:   pkt_nxt = pkt_count - 1'b1;
            default: pkt_nxt = pkt_count;
        endcase
        head_from_input = push && (data_count == {{(CNT_W-1){1'b0}}, pop});
        head_nxt        = head_from_input ? s_beat : mem[rd_ptr_nxt[AW-1:0]];
        load_head       = head_from_input || (pop && (cnt_nxt != '0));
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic in_pkt;
    logic in_pkt_nxt;

    // in_pkt keeps a started packet flowing, and a full FIFO with no tlast forces cut-through.
    assign in_pkt_nxt = pop ? !m_axis_tlast : in_pkt;
    assign valid_nxt  = (cnt_nxt != '0) &&
                        ((pkt_nxt != '0) || in_pkt_nxt || (cnt_nxt == FULL_CNT));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_pkt <= 1'b0;
        end else begin
            in_pkt <= in_pkt_nxt;
        end
    end
`else
    assign valid_nxt = (cnt_nxt != '0);
`endif

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_beat;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            data_count    <= '0;
            pkt_count     <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            data_count    <= cnt_nxt;
            pkt_count     <= pkt_nxt;
            s_axis_tready <= (cnt_nxt != FULL_CNT);
            m_axis_tvalid <= valid_nxt;
            if (load_head) begin
                {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} <= head_nxt;
            end
        end
    end

endmodule

// File: tb/tb_axis_param_fifo.sv
// Scoreboard testbench for axis_param_fifo; packet-mode scenarios build only with AXIS_FIFO_PACKET_MODE_EN.
module tb_axis_param_fifo;

    localparam int DATA_WIDTH = 32;
    localparam int USER_WIDTH = 1;
    localparam int DEPTH      = 16;
    localparam int CNT_W      = $clog2(DEPTH) + 1;
    localparam int KEEP_W     = DATA_WIDTH / 8;

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [KEEP_W-1:0]     s_axis_tkeep;
    logic [USER_WIDTH-1:0] s_axis_tuser;
    logic                  s_axis_tlast;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_W-1:0]     m_axis_tkeep;
    logic [USER_WIDTH-1:0] m_axis_tuser;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [CNT_W-1:0]      data_count;
    logic [CNT_W-1:0]      pkt_count;

    int          vectors     = 0;
    int          miscompares = 0;
    int          seq         = 0;
    logic [63:0] sb_q[$];

    axis_param_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .USER_WIDTH(USER_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .data_count   (data_count),
        .pkt_count    (pkt_count)
    );

    always #5 aclk = ~aclk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshakes seen at the negedge complete on the following rising edge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check_output("beat", {26'd0, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast},
                                 sb_q.pop_front());
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                sb_q.push_back({26'd0, s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast});
            end
        end
    end

    // mode 0: counting data, tlast every 4th beat; 1: fully random; 2: one packet, tlast on last beat
    task automatic load_beat(input int idx, input int n, input int mode);
        if (mode == 1) begin
            s_axis_tdata = $urandom;
            s_axis_tkeep = KEEP_W'($urandom);
            s_axis_tuser = USER_WIDTH'($urandom);
            s_axis_tlast = 1'($urandom);
        end else begin
            s_axis_tdata = DATA_WIDTH'(seq);
            s_axis_tkeep = '1;
            s_axis_tuser = USER_WIDTH'(seq);
            s_axis_tlast = (mode == 0) ? (seq % 4 == 3) : (idx == n - 1);
            seq++;
        end
    endtask

    task automatic apply_stimulus(input int n, input int mode, input int gap, input bit rnd);
        int  sent   = 0;
        int  idle   = 0;
        int  cycles = 0;
        bit  accepted;
        load_beat(0, n, mode);
        s_axis_tvalid = rnd ? 1'($urandom) : 1'b1;
        if (rnd) m_axis_tready = 1'($urandom);
        while (sent < n) begin
            @(negedge aclk);
            accepted = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            if (accepted) begin
                sent++;
                s_axis_tvalid = 1'b0;
                idle = 0;
                if (sent < n) load_beat(sent, n, mode);
            end
            if (!s_axis_tvalid && sent < n) begin
                if (idle >= gap && (!rnd || $urandom_range(1, 0) == 1)) s_axis_tvalid = 1'b1;
                else idle++;
            end
            if (rnd) m_axis_tready = 1'($urandom);
            cycles++;
            if (cycles > 5000) begin
                check_output("send_timeout", 64'd1, 64'd0);
                s_axis_tvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_empty(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk);
            if (data_count == '0 && !m_axis_tvalid) begin
                done = 1;
                break;
            end
        end
        check_output("drain_done", 64'(done), 64'd1);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;

        $display("[TB] reset");
        repeat (5) @(posedge aclk);
        #1;
        check_output("rst_tready", 64'(s_axis_tready), 64'd0);
        check_output("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_output("rst_counts", {data_count, pkt_count}, 64'd0);
        check_output("rst_mbeat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check_output("rel_tready", 64'(s_axis_tready), 64'd1);
        check_output("rel_count", 64'(data_count), 64'd0);

        $display("[TB] fill and drain");
        apply_stimulus(DEPTH, 0, 0, 0);
        check_output("full_count", 64'(data_count), 64'(DEPTH));
        check_output("full_pkts", 64'(pkt_count), 64'(DEPTH / 4));
        check_output("full_tready", 64'(s_axis_tready), 64'd0);
        check_output("full_head", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h0});
        m_axis_tready = 1'b1;
        wait_empty(DEPTH + 10);
        check_output("drained_pkts", 64'(pkt_count), 64'd0);
        check_output("drained_tready", 64'(s_axis_tready), 64'd1);

        $display("[TB] full throughput");
        m_axis_tready = 1'b0;
        apply_stimulus(3, 0, 0, 0);
        check_output("prefill_count", 64'(data_count), 64'd3);
        m_axis_tready = 1'b1;
        fork
            apply_stimulus(1000, 0, 0, 0);
            for (int i = 0; i < 1000; i++) begin
                @(negedge aclk);
                check_output("steady_count", {m_axis_tvalid, s_axis_tready, 3'b0, data_count},
                             {1'b1, 1'b1, 3'b0, 5'd3});
            end
        join
        wait_empty(20);

        $display("[TB] random backpressure");
        apply_stimulus(40, 1, 0, 1);
        m_axis_tready = 1'b1;
        wait_empty(DEPTH + 20);
        check_output("rnd_pkts", 64'(pkt_count), 64'd0);

`ifdef AXIS_FIFO_PACKET_MODE_EN
        $display("[TB] packet store-and-forward");
        m_axis_tready = 1'b1;
        fork
            apply_stimulus(5, 2, 1, 0);
            begin
                bit seen = 0;
                for (int i = 0; i < 60; i++) begin
                    @(negedge aclk);
                    if (m_axis_tvalid) begin
                        seen = 1;
                        break;
                    end
                end
                check_output("pkt_seen", 64'(seen), 64'd1);
                check_output("pkt_held", {data_count, pkt_count}, {5'd5, 5'd1});
                for (int i = 0; i < 5; i++) begin
                    check_output("pkt_burst", 64'(m_axis_tvalid), 64'd1);
                    @(negedge aclk);
                end
                check_output("pkt_after", {m_axis_tvalid, pkt_count}, {1'b0, 5'd0});
            end
        join
        wait_empty(20);

        $display("[TB] oversize packet");
        fork
            apply_stimulus(20, 2, 0, 0);
            begin
                bit seen = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge aclk);
                    if (m_axis_tvalid) begin
                        seen = 1;
                        break;
                    end
                end
                check_output("big_seen", 64'(seen), 64'd1);
                check_output("big_full", {data_count, pkt_count}, {5'(DEPTH), 5'd0});
            end
        join
        wait_empty(60);
`endif

        check_output("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
